// File: rtl/nv_nvdla_rt_intr_retime_if.sv
// Interrupt retime bundle: unit-side source pulses and ovf clears in, GLB-side delivery and status out.
// The master side drives pulses and rdy; the slave side is the retime pipe.
interface nv_nvdla_rt_intr_retime_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] intr_src_pd;
   logic             intr_dst_rdy;
   logic [WIDTH-1:0] intr_ovf_clr;
   logic [WIDTH-1:0] intr_dst_pd;
   logic [WIDTH-1:0] intr_pending;
   logic [WIDTH-1:0] intr_ovf;

   modport master (
      output intr_src_pd, intr_dst_rdy, intr_ovf_clr,
      input  intr_dst_pd, intr_pending, intr_ovf
   );

   modport slave (
      input  intr_src_pd, intr_dst_rdy, intr_ovf_clr,
      output intr_dst_pd, intr_pending, intr_ovf
   );
endinterface

// File: rtl/nv_nvdla_rt_intr_retime.sv
// Done-interrupt retime pipe: DEPTH reset-to-0 stages followed by a per-bit saturating
// pending counter, so GLB can stall delivery without losing pulses.
module nv_nvdla_rt_intr_retime #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 1,
   parameter int CNT_W = 3
) (
   input logic                      nvdla_core_clk,
   input logic                      nvdla_core_rstn,
   nv_nvdla_rt_intr_retime_if.slave intr
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] r;

   generate
      if (DEPTH == 0) begin : g_no_retime
         assign r = intr.intr_src_pd;
      end else begin : g_retime
         logic [DEPTH-1:0][WIDTH-1:0] stage_q;
         logic [DEPTH-1:0][WIDTH-1:0] stage_d;

         always_comb begin
            stage_d    = stage_q;
            stage_d[0] = intr.intr_src_pd;
            for (int k = 1; k < DEPTH; k++) begin
               stage_d[k] = stage_q[k-1];
            end
         end

         always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
               stage_q <= '0;
            end else begin
               stage_q <= stage_d;
            end
         end

         assign r = stage_q[DEPTH-1];
      end
   endgenerate

   logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0]            dst_pd_q;
   logic [WIDTH-1:0]            dst_pd_d;
   logic [WIDTH-1:0]            ovf_q;
   logic [WIDTH-1:0]            ovf_d;
   logic [WIDTH-1:0]            issue;
   logic [WIDTH-1:0]            drop;
   logic [WIDTH-1:0]            pending;

   // A fresh pulse that issues in its own arrival cycle bypasses the counter entirely.
   always_comb begin
      cnt_d = cnt_q;
      issue = '0;
      drop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         issue[i] = intr.intr_dst_rdy & ((cnt_q[i] != '0) | r[i]);
         if (r[i] & ~issue[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               drop[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end else if (~r[i] & issue[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
      dst_pd_d = issue;
      // A drop in the same cycle as a clear wins so the event is never lost silently.
      ovf_d    = drop | (ovf_q & ~intr.intr_ovf_clr);
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt_q    <= '0;
         dst_pd_q <= '0;
         ovf_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         dst_pd_q <= dst_pd_d;
         ovf_q    <= ovf_d;
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pending
      assign pending[gi] = |cnt_q[gi];
   end

   assign intr.intr_dst_pd  = dst_pd_q;
   assign intr.intr_pending = pending;
   assign intr.intr_ovf     = ovf_q;
endmodule

// File: tb/tb_nv_nvdla_rt_intr_retime.sv
// Bench for the interrupt retime pipe: three instances (DEPTH 1/0/4) checked every cycle
// against a scoreboard of predicted outputs, plus directed latency/stall/overflow checks.
module tb_nv_nvdla_rt_intr_retime;
   localparam int ND   = 3;
   localparam int MAXC = 7;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] src_v  [ND];
   logic       rdy_v  [ND];
   logic [3:0] clr_v  [ND];
   logic [3:0] dst_o  [ND];
   logic [3:0] pend_o [ND];
   logic [3:0] ovf_o  [ND];

   nv_nvdla_rt_intr_retime_if #(.WIDTH(2)) if0 ();
   nv_nvdla_rt_intr_retime_if #(.WIDTH(4)) if1 ();
   nv_nvdla_rt_intr_retime_if #(.WIDTH(4)) if2 ();

   assign if0.intr_src_pd  = src_v[0][1:0];
   assign if0.intr_dst_rdy = rdy_v[0];
   assign if0.intr_ovf_clr = clr_v[0][1:0];
   assign if1.intr_src_pd  = src_v[1];
   assign if1.intr_dst_rdy = rdy_v[1];
   assign if1.intr_ovf_clr = clr_v[1];
   assign if2.intr_src_pd  = src_v[2];
   assign if2.intr_dst_rdy = rdy_v[2];
   assign if2.intr_ovf_clr = clr_v[2];

   assign dst_o[0]  = {2'b00, if0.intr_dst_pd};
   assign pend_o[0] = {2'b00, if0.intr_pending};
   assign ovf_o[0]  = {2'b00, if0.intr_ovf};
   assign dst_o[1]  = if1.intr_dst_pd;
   assign pend_o[1] = if1.intr_pending;
   assign ovf_o[1]  = if1.intr_ovf;
   assign dst_o[2]  = if2.intr_dst_pd;
   assign pend_o[2] = if2.intr_pending;
   assign ovf_o[2]  = if2.intr_ovf;

   nv_nvdla_rt_intr_retime #(.WIDTH(2), .DEPTH(1), .CNT_W(3)) u_dut0 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .intr           (if0)
   );
   nv_nvdla_rt_intr_retime #(.WIDTH(4), .DEPTH(0), .CNT_W(3)) u_dut1 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .intr           (if1)
   );
   nv_nvdla_rt_intr_retime #(.WIDTH(4), .DEPTH(4), .CNT_W(3)) u_dut2 (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .intr           (if2)
   );

   typedef struct packed {
      logic [3:0] dst;
      logic [3:0] pend;
      logic [3:0] ovf;
   } exp_t;
   typedef exp_t [ND-1:0] exp3_t;

   exp3_t       sb_q [$];
   int          m_cnt  [ND][4];
   logic        m_ovf  [ND][4];
   logic [3:0]  m_dly  [ND][8];
   int          n_sent [ND][4];
   int          n_del  [ND][4];
   int          n_drop [ND][4];
   int          n_assert = 0;
   int          n_fail   = 0;

   function automatic int dep_of(int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 4;
      endcase
   endfunction

   function automatic int wid_of(int d);
      return (d == 0) ? 2 : 4;
   endfunction

   task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic set_src(logic [3:0] v);
      for (int d = 0; d < ND; d++) src_v[d] = v;
   endtask

   task automatic set_rdy(logic v);
      for (int d = 0; d < ND; d++) rdy_v[d] = v;
   endtask

   task automatic set_clr(logic [3:0] v);
      for (int d = 0; d < ND; d++) clr_v[d] = v;
   endtask

   // Predict the outputs after the next edge from the current inputs, then compare.
   task automatic step();
      exp3_t      e;
      logic [3:0] r;
      logic       iss;
      int         nxt;
      int         dp;
      for (int d = 0; d < ND; d++) begin
         e[d] = '0;
         if (!rstn) begin
            for (int k = 0; k < 8; k++) m_dly[d][k] = '0;
            for (int i = 0; i < 4; i++) begin
               m_cnt[d][i] = 0;
               m_ovf[d][i] = 1'b0;
            end
         end else begin
            dp = dep_of(d);
            if (dp == 0) r = src_v[d];
            else         r = m_dly[d][dp-1];
            for (int k = 7; k > 0; k--) m_dly[d][k] = m_dly[d][k-1];
            m_dly[d][0] = src_v[d];
            for (int i = 0; i < wid_of(d); i++) begin
               if (src_v[d][i]) n_sent[d][i]++;
               iss = rdy_v[d] && (m_cnt[d][i] != 0 || r[i]);
               nxt = m_cnt[d][i] + int'(r[i]) - int'(iss);
               if (nxt > MAXC) begin
                  nxt = MAXC;
                  n_drop[d][i]++;
                  m_ovf[d][i] = 1'b1;
               end else begin
                  m_ovf[d][i] = m_ovf[d][i] & ~clr_v[d][i];
               end
               m_cnt[d][i]   = nxt;
               e[d].dst[i]   = iss;
               e[d].pend[i]  = (nxt != 0);
               e[d].ovf[i]   = m_ovf[d][i];
            end
         end
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      for (int d = 0; d < ND; d++) begin
         check("sb_dst",  d, dst_o[d],  e[d].dst);
         check("sb_pend", d, pend_o[d], e[d].pend);
         check("sb_ovf",  d, ovf_o[d],  e[d].ovf);
         for (int i = 0; i < wid_of(d); i++) begin
            if (dst_o[d][i]) n_del[d][i]++;
         end
      end
   endtask

   task automatic clear_acct();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 4; i++) begin
            n_sent[d][i] = 0;
            n_del[d][i]  = 0;
            n_drop[d][i] = 0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_first [ND];
      int lat_hits  [ND];
      int hits;
      int first;
      int last;
      logic pend_seen;

      clear_acct();
      set_src(4'h0);
      set_rdy(1'b1);
      set_clr(4'h0);

      // Reset held with sources active: nothing may come out.
      rstn = 1'b0;
      set_src(4'hf);
      repeat (4) begin
         step();
         check("rst_dst",  0, dst_o[0],  32'h0);
         check("rst_pend", 0, pend_o[0], 32'h0);
         check("rst_ovf",  0, ovf_o[0],  32'h0);
      end
      rstn = 1'b1;
      set_src(4'h0);
      repeat (3) begin
         step();
         check("post_rst_dst", 0, dst_o[0], 32'h0);
      end
      $display("phase reset: done, outputs idle");

      // Single pulse latency on bit 0 of every instance.
      for (int d = 0; d < ND; d++) begin
         lat_first[d] = -1;
         lat_hits[d]  = 0;
      end
      pend_seen = 1'b0;
      set_src(4'h1);
      for (int n = 1; n <= 10; n++) begin
         step();
         set_src(4'h0);
         if (pend_o[0][0]) pend_seen = 1'b1;
         for (int d = 0; d < ND; d++) begin
            if (dst_o[d][0]) begin
               lat_hits[d]++;
               if (lat_first[d] < 0) lat_first[d] = n;
            end
         end
      end
      for (int d = 0; d < ND; d++) begin
         check("lat_first", d, lat_first[d], dep_of(d) + 1);
         check("lat_hits",  d, lat_hits[d], 1);
         $display("phase latency: dut%0d first=%0d hits=%0d", d, lat_first[d], lat_hits[d]);
      end
      check("lat_pend", 0, {31'h0, pend_seen}, 32'h0);

      // Stall with five pulses on bit 1, then drain.
      set_rdy(1'b0);
      repeat (5) begin
         set_src(4'h2);
         step();
         set_src(4'h0);
         step();
      end
      repeat (6) step();
      check("stall_pend", 0, {31'h0, pend_o[0][1]}, 32'h1);
      check("stall_dst",  0, dst_o[0], 32'h0);
      set_rdy(1'b1);
      hits = 0; first = -1; last = -1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (dst_o[0][1]) begin
            hits++;
            if (first < 0) first = n;
            last = n;
         end
      end
      check("drain_hits", 0, hits, 5);
      check("drain_run",  0, last - first + 1, 5);
      check("drain_pend", 0, {31'h0, pend_o[0][1]}, 32'h0);
      $display("phase stall: drained=%0d span=%0d", hits, last - first + 1);

      // Nine pulses into a 7-deep counter while stalled.
      set_rdy(1'b0);
      repeat (9) begin
         set_src(4'h1);
         step();
         set_src(4'h0);
         step();
      end
      repeat (6) step();
      for (int d = 0; d < ND; d++) check("ovf_set", d, ovf_o[d], 32'h1);
      set_rdy(1'b1);
      hits = 0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (dst_o[0][0]) hits++;
      end
      check("ovf_drain_hits", 0, hits, 7);
      check("ovf_sticky", 0, ovf_o[0], 32'h1);
      set_clr(4'h1);
      step();
      set_clr(4'h0);
      check("ovf_clr", 0, ovf_o[0], 32'h0);
      $display("phase overflow: drained=%0d", hits);

      // Saturated counter with simultaneous arrival and issue, then drop against clear.
      set_rdy(1'b0);
      set_src(4'h1);
      repeat (8) step();
      check("sat_pend", 0, {31'h0, pend_o[0][0]}, 32'h1);
      check("sat_ovf0", 0, {31'h0, ovf_o[0][0]}, 32'h0);
      set_rdy(1'b1);
      repeat (4) begin
         step();
         check("sim_dst", 0, {31'h0, dst_o[0][0]}, 32'h1);
         check("sim_ovf", 0, {31'h0, ovf_o[0][0]}, 32'h0);
         check("sim_pend", 0, {31'h0, pend_o[0][0]}, 32'h1);
      end
      set_rdy(1'b0);
      set_clr(4'hf);
      repeat (2) begin
         step();
         check("drop_vs_clr", 0, {31'h0, ovf_o[0][0]}, 32'h1);
      end
      set_src(4'h0);
      set_rdy(1'b1);
      repeat (14) step();
      set_clr(4'h0);
      step();
      check("sat_clean_pend", 0, pend_o[0], 32'h0);
      check("sat_clean_ovf",  0, ovf_o[0],  32'h0);
      $display("phase saturate: done");

      // Reset while events are pending: none may surface afterwards.
      set_rdy(1'b0);
      repeat (3) begin
         set_src(4'h1);
         step();
         set_src(4'h0);
         step();
      end
      check("mid_pend", 0, {31'h0, pend_o[0][0]}, 32'h1);
      rstn = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
      set_rdy(1'b1);
      hits = 0;
      repeat (8) begin
         step();
         for (int d = 0; d < ND; d++) if (dst_o[d] != 4'h0) hits++;
      end
      check("mid_rst_hits", 0, hits, 0);
      $display("phase mid-reset: pulses after reset=%0d", hits);

      // Random traffic on all instances, then drain and balance the books.
      clear_acct();
      repeat (600) begin
         for (int d = 0; d < ND; d++) begin
            src_v[d] = 4'($urandom_range(0, 15));
            rdy_v[d] = ($urandom_range(0, 9) < 7);
            clr_v[d] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         end
         step();
      end
      set_src(4'h0);
      set_rdy(1'b1);
      set_clr(4'h0);
      repeat (16) step();
      for (int d = 0; d < ND; d++) begin
         check("rand_pend", d, pend_o[d], 32'h0);
         for (int i = 0; i < wid_of(d); i++) begin
            check("rand_acct", d, n_del[d][i] + n_drop[d][i], n_sent[d][i]);
            $display("phase random: dut%0d bit%0d sent=%0d delivered=%0d dropped=%0d",
                     d, i, n_sent[d][i], n_del[d][i], n_drop[d][i]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
